reg_bank_clk: RTL
=================

// Module: reg_bank_clk
// PURPOSE
// - Clocked, parametrised successor to the latch-style A/X/Y/S registers: one bank holding accumulator A, index X/Y and stack pointer S.
// - Sits between SB/DB/ADL buses and ALU/DAA path; all writes synchronous, bus reads combinational from stored state.
// - Adds stack-pointer increment/decrement with wrap flag, bus-contention detection, and optional bus-hold mode.
// PARAMETERS
// - DATA_W    8      width of every register and bus
// - S_RESET   8'hFD  stack pointer value after reset (truncated/zero-extended to DATA_W)
// - BUS_HOLD  0      1: SB_OUT/DB_OUT/ADL_OUT hold last driven value when undriven; 0: drive 0
// PORTS
// - CLK        in   1       rising-edge clock
// - RST_N      in   1       asynchronous active-low reset
// - SB_DATA    in   DATA_W  special bus, source for X/Y/S loads
// - DAA_DATA   in   DATA_W  decimal-adjust output, source for A load
// - A_LOAD     in   1       load A from DAA_DATA
// - X_LOAD     in   1       load X from SB_DATA
// - Y_LOAD     in   1       load Y from SB_DATA
// - S_LOAD     in   1       load S from SB_DATA
// - S_INC      in   1       S <= S+1 (pop)
// - S_DEC      in   1       S <= S-1 (push)
// - SB_SEL     in   4       one-hot SB driver select {S,Y,X,A} (bit0=A)
// - DB_A_EN    in   1       drive A onto DB_OUT
// - ADL_S_EN   in   1       drive S onto ADL_OUT
// - ERR_CLR    in   1       clear sticky CONTENTION
// - SB_OUT     out  DATA_W  special bus output
// - DB_OUT     out  DATA_W  data bus output
// - ADL_OUT    out  DATA_W  address-low bus output
// - S_WRAP     out  1       one-cycle pulse: S wrapped via INC or DEC
// - CONTENTION out  1       sticky: >1 SB_SEL bit, or S_INC&S_DEC, seen in a cycle
// BEHAVIOUR
// - Reset (RST_N=0, async): A=X=Y=0, S=S_RESET, hold regs=0, S_WRAP=0, CONTENTION=0; all outputs 0 while in reset.
// - Write latency 1 cycle: value loaded at edge N visible on outputs after edge N; same-cycle read returns old value.
// - Loads to different registers in same cycle all take effect independently.
// - S priority: S_LOAD > (S_INC xor S_DEC) > hold; S_INC&S_DEC without S_LOAD: S holds, CONTENTION set.
// - Arithmetic modulo 2^DATA_W: INC from all-ones -> 0, DEC from 0 -> all-ones; S_WRAP=1 the cycle after that edge only.
// - S_LOAD never raises S_WRAP, even if INC/DEC also asserted.
// - SB_OUT: exactly one SB_SEL bit -> selected register; zero bits -> undriven; >1 bits -> undriven and CONTENTION set at next edge.
// - DB_OUT = A when DB_A_EN else undriven; ADL_OUT = S when ADL_S_EN else undriven.
// - Undriven: BUS_HOLD=0 -> 0; BUS_HOLD=1 -> last value driven, captured each edge where bus was driven (hold reg per bus).
// - CONTENTION: sticky until ERR_CLR; ERR_CLR and new error same cycle -> set wins.
// - Reset mid-operation aborts pending loads immediately; first post-reset edge acts on inputs normally.
// STRUCTURE
// - Shared package: SB_SEL bit indices (SEL_A=0..SEL_S=3), default S_RESET, register index enum.
// - One sub-module natural: reg_bank_bus_hold (DATA_W-wide driven/undriven mux with optional hold register), instantiated x3.
// - S update logic, contention detection and A/X/Y storage stay in the top.
// TESTING
// - Reset: RST_N low mid-cycle with A=8'h55 -> A/X/Y=0, S=8'hFD, outputs 0 immediately, no wait for CLK.
// - Loads: SB_DATA=8'h3C, X_LOAD=1; next cycle SB_SEL=4'b0010 -> SB_OUT=8'h3C; same-cycle read showed old X.
// - Stack: S_LOAD 8'h00 then S_DEC -> S=8'hFF, S_WRAP pulses 1 cycle; S_INC -> S=8'h00, S_WRAP pulses again.
// - Priority: S=8'h10, S_LOAD(8'h80)+S_INC -> S=8'h80, no wrap; S_INC+S_DEC -> S=8'h10, CONTENTION=1.
// - Contention: SB_SEL=4'b0011 -> SB_OUT undriven, CONTENTION=1 sticky; ERR_CLR -> 0; ERR_CLR with SB_SEL=4'b1100 -> stays 1.
// - Bus hold: BUS_HOLD=1, drive A=8'hA5 on DB then DB_A_EN=0 -> DB_OUT stays 8'hA5; BUS_HOLD=0 -> 8'h00.

Source files
------------

// File: rtl/reg_bank_clk_pkg.sv
// Shared definitions for the clocked A/X/Y/S register bank.
// SB driver select bit positions, register indices and reset defaults.
package reg_bank_clk_pkg;

    localparam int SEL_A = 0;
    localparam int SEL_X = 1;
    localparam int SEL_Y = 2;
    localparam int SEL_S = 3;
    localparam int SEL_W = 4;

    localparam logic [7:0] S_RESET_DEF = 8'hFD;

    typedef enum logic [1:0] {
        REG_A = 2'd0,
        REG_X = 2'd1,
        REG_Y = 2'd2,
        REG_S = 2'd3
    } reg_idx_e;

    function automatic logic [2:0] sel_count(
        input logic [SEL_W-1:0] sel
    );
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < SEL_W; i++) begin
            n = n + 3'(sel[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/reg_bank_clk_bus_hold.sv
// Bus output stage: drives data when enabled, otherwise zero or the
// last value driven at a clock edge. Forced to zero while in reset.
module reg_bank_bus_hold #(
    parameter int DATA_W   = 8,
    parameter bit BUS_HOLD = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              drive_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] bus_o
);

    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] hold_d;

    always_comb begin
        hold_d = hold_q;
        if (drive_i) begin
            hold_d = data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    always_comb begin
        bus_o = '0;
        if (rst_ni) begin
            if (drive_i) begin
                bus_o = data_i;
            end else if (BUS_HOLD) begin
                bus_o = hold_q;
            end
        end
    end

endmodule

// File: rtl/reg_bank_clk.sv
// Clocked A/X/Y/S register bank with stack-pointer arithmetic,
// SB contention detection and optional bus-hold outputs.
module reg_bank_clk
    import reg_bank_clk_pkg::*;
#(
    parameter int         DATA_W   = 8,
    parameter logic [7:0] S_RESET  = S_RESET_DEF,
    parameter bit         BUS_HOLD = 1'b0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] SB_DATA,
    input  logic [DATA_W-1:0] DAA_DATA,
    input  logic              A_LOAD,
    input  logic              X_LOAD,
    input  logic              Y_LOAD,
    input  logic              S_LOAD,
    input  logic              S_INC,
    input  logic              S_DEC,
    input  logic [SEL_W-1:0]  SB_SEL,
    input  logic              DB_A_EN,
    input  logic              ADL_S_EN,
    input  logic              ERR_CLR,
    output logic [DATA_W-1:0] SB_OUT,
    output logic [DATA_W-1:0] DB_OUT,
    output logic [DATA_W-1:0] ADL_OUT,
    output logic              S_WRAP,
    output logic              CONTENTION
);

    localparam logic [DATA_W-1:0] S_RST = DATA_W'(S_RESET);
    localparam logic [DATA_W-1:0] ONE   = DATA_W'(1);

    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] x_q, x_d;
    logic [DATA_W-1:0] y_q, y_d;
    logic [DATA_W-1:0] s_q, s_d;
    logic              wrap_q, wrap_d;
    logic              cont_q, cont_d;

    logic [2:0]        sel_n;
    logic              sb_one;
    logic              sb_multi;
    logic              ss_clash;
    reg_idx_e          sb_idx;
    logic [DATA_W-1:0] sb_val;

    assign sel_n    = sel_count(SB_SEL);
    assign sb_one   = (sel_n == 3'd1);
    assign sb_multi = (sel_n > 3'd1);
    assign ss_clash = S_INC & S_DEC;

    always_comb begin
        sb_idx = REG_A;
        if (sb_one) begin
            unique case (1'b1)
                SB_SEL[SEL_A]: sb_idx = REG_A;
                SB_SEL[SEL_X]: sb_idx = REG_X;
                SB_SEL[SEL_Y]: sb_idx = REG_Y;
                SB_SEL[SEL_S]: sb_idx = REG_S;
            endcase
        end
    end

    always_comb begin
        sb_val = '0;
        unique case (sb_idx)
            REG_A: sb_val = a_q;
            REG_X: sb_val = x_q;
            REG_Y: sb_val = y_q;
            REG_S: sb_val = s_q;
        endcase
    end

    always_comb begin
        a_d = A_LOAD ? DAA_DATA : a_q;
        x_d = X_LOAD ? SB_DATA : x_q;
        y_d = Y_LOAD ? SB_DATA : y_q;
    end

    // A load wins outright and never reports a wrap; inc+dec cancel.
    always_comb begin
        s_d    = s_q;
        wrap_d = 1'b0;
        if (S_LOAD) begin
            s_d = SB_DATA;
        end else if (S_INC && !S_DEC) begin
            s_d    = s_q + ONE;
            wrap_d = &s_q;
        end else if (S_DEC && !S_INC) begin
            s_d    = s_q - ONE;
            wrap_d = ~|s_q;
        end
    end

    always_comb begin
        cont_d = cont_q;
        if (sb_multi || ss_clash) begin
            cont_d = 1'b1;
        end else if (ERR_CLR) begin
            cont_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a_q    <= '0;
            x_q    <= '0;
            y_q    <= '0;
            s_q    <= S_RST;
            wrap_q <= 1'b0;
            cont_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            x_q    <= x_d;
            y_q    <= y_d;
            s_q    <= s_d;
            wrap_q <= wrap_d;
            cont_q <= cont_d;
        end
    end

    reg_bank_bus_hold #(
        .DATA_W  (DATA_W),
        .BUS_HOLD(BUS_HOLD)
    ) u_sb_bus (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .drive_i(sb_one),
        .data_i (sb_val),
        .bus_o  (SB_OUT)
    );

    reg_bank_bus_hold #(
        .DATA_W  (DATA_W),
        .BUS_HOLD(BUS_HOLD)
    ) u_db_bus (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .drive_i(DB_A_EN),
        .data_i (a_q),
        .bus_o  (DB_OUT)
    );

    reg_bank_bus_hold #(
        .DATA_W  (DATA_W),
        .BUS_HOLD(BUS_HOLD)
    ) u_adl_bus (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .drive_i(ADL_S_EN),
        .data_i (s_q),
        .bus_o  (ADL_OUT)
    );

    assign S_WRAP     = wrap_q;
    assign CONTENTION = cont_q;

endmodule
